mmio_key_art_responder: RTL and testbench

Memory-mapped I/O responder on the core's single-cycle bus: it is the target side that the CPU's `bus_*` load/store accesses hit.
- Collects keyboard bytes into an RX FIFO, raises `interrupt_vector = 1` while key data waits, and retires it on `interrupt_done`.
- Drains CPU writes through a TX FIFO to the display/serial ("ART") sink.
- Sits between the core and the keyboard/display front-ends in the board top level.

---
 rtl/mmio_pkg.sv | 44 ++++
 rtl/byte_fifo.sv | 60 ++++++
 rtl/mmio_key_art_responder.sv | 172 +++++++++++++++++
 tb/tb_mmio_key_art_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO key/ART responder: register map, IRQ code,
// FSM encoding and status register layouts.
package mmio_pkg;

    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned VEC_W     = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

    localparam logic [REG_IDX_W-1:0] REG_ART_DATA   = 3'd0;
    localparam logic [REG_IDX_W-1:0] REG_ART_STATUS = 3'd1;
    localparam logic [REG_IDX_W-1:0] REG_KEY_DATA   = 3'd2;
    localparam logic [REG_IDX_W-1:0] REG_KEY_STATUS = 3'd3;
    localparam logic [REG_IDX_W-1:0] REG_IRQ_CTRL   = 3'd4;

    localparam logic [VEC_W-1:0] IRQ_VEC_KEY  = 4'd1;
    localparam logic [VEC_W-1:0] IRQ_VEC_NONE = 4'd0;

    typedef enum logic {
        IRQ_IDLE,
        IRQ_PENDING
    } irq_state_e;

    typedef struct packed {
        logic [47:0] rsvd_hi;
        logic [7:0]  count;
        logic [4:0]  rsvd_lo;
        logic        ovf;
        logic        empty;
        logic        full;
    } art_status_t;

    typedef struct packed {
        logic [47:0] rsvd_hi;
        logic [7:0]  count;
        logic [5:0]  rsvd_lo;
        logic        ovf;
        logic        nonempty;
    } key_status_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO; a push while full is accepted only when a pop
// happens in the same cycle, a pop while empty is ignored.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [7:0]                   data_i,
    input  logic                         pop_i,
    output logic                         full_c,
    output logic                         empty_c,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [7:0]                   head_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_eff_c, pop_eff_c;

    assign full_c     = (count_q == CW'(DEPTH));
    assign empty_c    = (count_q == '0);
    assign pop_eff_c  = pop_i && !empty_c;
    assign push_eff_c = push_i && (!full_c || pop_eff_c);
    assign count_o    = count_q;
    // Head reads as zero when empty so downstream never sees stale storage.
    assign head_c     = empty_c ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_eff_c)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_eff_c && !pop_eff_c)      count_d = count_q + CW'(1);
        else if (pop_eff_c && !push_eff_c) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff_c) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mmio_key_art_responder.sv
// MMIO target: keyboard RX FIFO with key interrupt, ART TX FIFO, and a
// 64-byte register window decoded on the core's single-cycle bus.
module mmio_key_art_responder
    import mmio_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned RX_DEPTH  = 8,
    parameter int unsigned TX_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] bus_address,
    input  logic [DATA_W-1:0] bus_write_data,
    input  logic              bus_write_enable,
    input  logic              bus_read_enable,
    output logic [DATA_W-1:0] bus_read_data,
    output logic [VEC_W-1:0]  interrupt_vector,
    input  logic              interrupt_done,
    input  logic              key_valid,
    input  logic [BYTE_W-1:0] key_data,
    output logic              key_ready,
    output logic              art_valid,
    output logic [BYTE_W-1:0] art_data,
    input  logic              art_ready
);

    localparam int unsigned RX_CW = $clog2(RX_DEPTH + 1);
    localparam int unsigned TX_CW = $clog2(TX_DEPTH + 1);

    logic                 hit_c, wr_hit_c, rd_hit_c;
    logic [REG_IDX_W-1:0] reg_idx_c;
    logic                 unused_c;

    logic                 rx_push_c, rx_pop_c, rx_full_c, rx_empty_c, rx_drain_c;
    logic [RX_CW-1:0]     rx_count_c;
    logic [BYTE_W-1:0]    rx_head_c;
    logic                 tx_push_c, tx_full_c, tx_empty_c;
    logic [TX_CW-1:0]     tx_count_c;
    logic [BYTE_W-1:0]    tx_head_c;
    logic                 irq_wr_c;

    logic                 irq_en_q, irq_en_d;
    logic                 rx_ovf_q, rx_ovf_d;
    logic                 tx_ovf_q, tx_ovf_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    irq_state_e           state_q, state_d;
    logic [VEC_W-1:0]     vector_q, vector_d;

    art_status_t          art_st_c;
    key_status_t          key_st_c;

    assign hit_c     = (bus_address[63:6] == BASE_ADDR[63:6]);
    assign reg_idx_c = bus_address[5:3];
    assign wr_hit_c  = bus_write_enable && hit_c;
    assign rd_hit_c  = bus_read_enable && hit_c;
    assign unused_c  = ^{bus_address[2:0], bus_write_data[63:8]};

    assign irq_wr_c  = wr_hit_c && (reg_idx_c == REG_IRQ_CTRL);
    assign tx_push_c = wr_hit_c && (reg_idx_c == REG_ART_DATA);
    assign rx_push_c = key_valid && key_ready;
    assign rx_pop_c  = rd_hit_c && (reg_idx_c == REG_KEY_DATA);
    // A KEY_DATA read of the last byte with no key arriving empties RX.
    assign rx_drain_c = rx_pop_c && (rx_count_c == RX_CW'(1)) && !rx_push_c;

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push_c),
        .data_i  (key_data),
        .pop_i   (rx_pop_c),
        .full_c  (rx_full_c),
        .empty_c (rx_empty_c),
        .count_o (rx_count_c),
        .head_c  (rx_head_c)
    );

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_push_c),
        .data_i  (bus_write_data[7:0]),
        .pop_i   (art_ready),
        .full_c  (tx_full_c),
        .empty_c (tx_empty_c),
        .count_o (tx_count_c),
        .head_c  (tx_head_c)
    );

    assign key_ready = !rx_full_c;
    assign art_valid = !tx_empty_c;
    assign art_data  = tx_head_c;

    always_comb begin
        art_st_c         = '0;
        art_st_c.count   = 8'(tx_count_c);
        art_st_c.ovf     = tx_ovf_q;
        art_st_c.empty   = tx_empty_c;
        art_st_c.full    = tx_full_c;
        key_st_c         = '0;
        key_st_c.count   = 8'(rx_count_c);
        key_st_c.ovf     = rx_ovf_q;
        key_st_c.nonempty = !rx_empty_c;
    end

    // Control/status registers and read-data capture.
    always_comb begin
        irq_en_d = irq_en_q;
        rx_ovf_d = rx_ovf_q;
        tx_ovf_d = tx_ovf_q;
        rdata_d  = rdata_q;
        if (irq_wr_c) begin
            irq_en_d = bus_write_data[0];
            if (bus_write_data[1]) begin
                rx_ovf_d = 1'b0;
                tx_ovf_d = 1'b0;
            end
        end
        // A drop in the same cycle as a clear still leaves the flag set.
        if (key_valid && !key_ready)                rx_ovf_d = 1'b1;
        if (tx_push_c && tx_full_c && !art_ready)   tx_ovf_d = 1'b1;
        if (bus_read_enable) begin
            rdata_d = '0;
            if (hit_c) begin
                case (reg_idx_c)
                    REG_ART_STATUS: rdata_d = art_st_c;
                    REG_KEY_DATA:   rdata_d = {56'd0, rx_head_c};
                    REG_KEY_STATUS: rdata_d = key_st_c;
                    REG_IRQ_CTRL:   rdata_d = {63'd0, irq_en_q};
                    default:        rdata_d = '0;
                endcase
            end
        end
    end

    // Key interrupt FSM; the vector is registered from the current state.
    always_comb begin
        state_d  = state_q;
        vector_d = (state_q == IRQ_PENDING) ? IRQ_VEC_KEY : IRQ_VEC_NONE;
        case (state_q)
            IRQ_IDLE: begin
                if (irq_en_q && !rx_empty_c) state_d = IRQ_PENDING;
            end
            IRQ_PENDING: begin
                if (interrupt_done || rx_drain_c || (irq_wr_c && !bus_write_data[0]))
                    state_d = IRQ_IDLE;
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_q <= 1'b0;
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            rdata_q  <= '0;
            state_q  <= IRQ_IDLE;
            vector_q <= IRQ_VEC_NONE;
        end else begin
            irq_en_q <= irq_en_d;
            rx_ovf_q <= rx_ovf_d;
            tx_ovf_q <= tx_ovf_d;
            rdata_q  <= rdata_d;
            state_q  <= state_d;
            vector_q <= vector_d;
        end
    end

    assign bus_read_data    = rdata_q;
    assign interrupt_vector = vector_q;

endmodule

// File: tb/tb_mmio_key_art_responder.sv
// Scoreboard bench for mmio_key_art_responder: stimulus queues expected read
// data and ART bytes, monitors pop and compare as the DUT presents them.
module tb_mmio_key_art_responder;

    localparam logic [63:0] A_ART  = 64'h8000_0000;
    localparam logic [63:0] A_ARTS = 64'h8000_0008;
    localparam logic [63:0] A_KEY  = 64'h8000_0010;
    localparam logic [63:0] A_KEYS = 64'h8000_0018;
    localparam logic [63:0] A_IRQ  = 64'h8000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] bus_address = '0;
    logic [63:0] bus_write_data = '0;
    logic        bus_write_enable = 1'b0;
    logic        bus_read_enable = 1'b0;
    logic [63:0] bus_read_data;
    logic [3:0]  interrupt_vector;
    logic        interrupt_done = 1'b0;
    logic        key_valid = 1'b0;
    logic [7:0]  key_data = '0;
    logic        key_ready;
    logic        art_valid;
    logic [7:0]  art_data;
    logic        art_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [63:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [7:0]  art_exp_q[$];
    logic        rd_seen;

    mmio_key_art_responder #(
        .BASE_ADDR (64'h8000_0000),
        .RX_DEPTH  (8),
        .TX_DEPTH  (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_write_enable (bus_write_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_read_data    (bus_read_data),
        .interrupt_vector (interrupt_vector),
        .interrupt_done   (interrupt_done),
        .key_valid        (key_valid),
        .key_data         (key_data),
        .key_ready        (key_ready),
        .art_valid        (art_valid),
        .art_data         (art_data),
        .art_ready        (art_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read-data monitor: one result per read strobe seen at the previous edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) rd_seen <= 1'b0;
        else        rd_seen <= bus_read_enable;
    end

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got %h with no expected entry", bus_read_data);
            end else begin
                check(rd_name_q.pop_front(), bus_read_data, rd_exp_q.pop_front());
            end
        end
    end

    // ART sink monitor: pre-edge values are seen here before registers update.
    always @(posedge clk) begin
        if (reset === 1'b1 && art_valid && art_ready) begin
            if (art_exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL art_unexpected: got %h with no expected byte", art_data);
            end else begin
                check("art_data", 64'(art_data), 64'(art_exp_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        bus_address      = a;
        bus_write_data   = d;
        bus_write_enable = 1'b1;
        @(negedge clk);
        bus_write_enable = 1'b0;
    endtask

    task automatic rd(input logic [63:0] a, input logic [63:0] e, input string n);
        bus_address     = a;
        bus_read_enable = 1'b1;
        rd_exp_q.push_back(e);
        rd_name_q.push_back(n);
        @(negedge clk);
        bus_read_enable = 1'b0;
    endtask

    task automatic key(input logic [7:0] b);
        key_valid = 1'b1;
        key_data  = b;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, %0d checks so far", tests);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;
        idle(3);
        check("rst_rdata",  bus_read_data, 64'h0);
        check("rst_vector", 64'(interrupt_vector), 64'h0);
        check("rst_art_valid", 64'(art_valid), 64'h0);
        check("rst_art_data",  64'(art_data), 64'h0);
        check("rst_key_ready", 64'(key_ready), 64'h1);
        reset = 1'b1;
        idle(1);

        rd(A_KEYS, 64'h0, "key_status_reset");
        check("t1_key_ready", 64'(key_ready), 64'h1);
        check("t1_vector", 64'(interrupt_vector), 64'h0);
        check("t1_art_valid", 64'(art_valid), 64'h0);

        art_ready = 1'b0;
        art_exp_q.push_back(8'h41);
        wr(A_ART, 64'h41);
        check("t2_art_valid", 64'(art_valid), 64'h1);
        check("t2_art_data", 64'(art_data), 64'h41);
        art_ready = 1'b1;
        idle(1);
        art_ready = 1'b0;
        check("t2_art_drained", 64'(art_valid), 64'h0);

        wr(64'h9000_0000, 64'h99);
        check("miss_write_ignored", 64'(art_valid), 64'h0);
        rd(64'h8000_0048, 64'h0, "miss_next_window");
        rd(64'h1_8000_0008, 64'h0, "miss_high_bits");
        rd(64'h8000_0028, 64'h0, "unmapped_idx5");
        rd(64'h8000_000B, 64'h2, "art_status_low_bits");

        wr(A_IRQ, 64'h1);
        key(8'h61);
        check("t3_vec_n0", 64'(interrupt_vector), 64'h0);
        idle(1);
        check("t3_vec_n1", 64'(interrupt_vector), 64'h0);
        idle(1);
        check("t3_vec_n2", 64'(interrupt_vector), 64'h1);
        rd(A_KEY, 64'h61, "key_data_61");
        check("t3_vec_hold", 64'(interrupt_vector), 64'h1);
        idle(1);
        check("t3_vec_drop", 64'(interrupt_vector), 64'h0);

        for (int i = 0; i < 9; i++) key(8'(8'h30 + i));
        check("t4_key_ready_full", 64'(key_ready), 64'h0);
        rd(A_KEYS, 64'h0803, "key_status_ovf");
        wr(A_IRQ, 64'h3);
        rd(A_KEYS, 64'h0801, "key_status_cleared");
        rd(A_IRQ, 64'h1, "irq_en_kept");
        check("t4_vector", 64'(interrupt_vector), 64'h1);

        for (int i = 0; i < 6; i++) rd(A_KEY, 64'(8'h30 + i), "key_fifo_order");
        check("t5_vec_before_done", 64'(interrupt_vector), 64'h1);
        interrupt_done = 1'b1;
        idle(1);
        interrupt_done = 1'b0;
        check("t5_vec_m0", 64'(interrupt_vector), 64'h1);
        idle(1);
        check("t5_vec_m1", 64'(interrupt_vector), 64'h0);
        idle(1);
        check("t5_vec_rearm", 64'(interrupt_vector), 64'h1);
        rd(A_KEY, 64'h36, "key_data_36");
        rd(A_KEY, 64'h37, "key_data_37");
        rd(A_KEY, 64'h0, "key_data_empty");
        rd(A_KEYS, 64'h0, "key_status_empty");
        check("t5_vec_idle", 64'(interrupt_vector), 64'h0);

        bus_address      = A_IRQ;
        bus_write_data   = 64'h0;
        bus_write_enable = 1'b1;
        bus_read_enable  = 1'b1;
        rd_exp_q.push_back(64'h1);
        rd_name_q.push_back("irq_rw_old");
        idle(1);
        bus_write_enable = 1'b0;
        bus_read_enable  = 1'b0;
        rd(A_IRQ, 64'h0, "irq_rw_new");
        wr(A_IRQ, 64'h1);

        art_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            art_exp_q.push_back(8'(8'hA0 + i));
            wr(A_ART, 64'(8'hA0 + i));
        end
        rd(A_ARTS, 64'h0801, "tx_full_status");
        art_exp_q.push_back(8'hA8);
        bus_address      = A_ART;
        bus_write_data   = 64'hA8;
        bus_write_enable = 1'b1;
        art_ready        = 1'b1;
        idle(1);
        bus_write_enable = 1'b0;
        art_ready        = 1'b0;
        rd(A_ARTS, 64'h0801, "tx_push_pop_full");
        wr(A_ART, 64'hEE);
        rd(A_ARTS, 64'h0805, "tx_ovf_set");
        art_ready = 1'b1;
        idle(2);
        art_ready = 1'b0;
        rd(A_ARTS, 64'h0604, "tx_count_after_pops");

        key(8'h7A);
        idle(2);
        check("t6_vec_before_reset", 64'(interrupt_vector), 64'h1);
        reset = 1'b0;
        #1;
        check("rst_mid_art_valid", 64'(art_valid), 64'h0);
        check("rst_mid_art_data", 64'(art_data), 64'h0);
        check("rst_mid_vector", 64'(interrupt_vector), 64'h0);
        check("rst_mid_rdata", bus_read_data, 64'h0);
        check("rst_mid_key_ready", 64'(key_ready), 64'h1);
        art_exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        rd(A_ARTS, 64'h2, "tx_after_reset");
        rd(A_KEYS, 64'h0, "rx_after_reset");
        rd(A_IRQ, 64'h0, "irq_en_after_reset");
        check("post_rst_vector", 64'(interrupt_vector), 64'h0);
        check("post_rst_art_valid", 64'(art_valid), 64'h0);

        idle(2);
        check("rd_queue_drained", 64'(rd_exp_q.size()), 64'h0);
        check("art_queue_drained", 64'(art_exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
